// File: rtl/vector_scan_iter.sv
// vector_scan_iter
//   Accepts a WIDTH-bit vector and then emits each set bit in priority order,
//   one beat per output handshake. MSB_FIRST selects whether the highest or
//   the lowest set bit is serviced first. An all-zero vector produces a single
//   beat flagged with out_zero.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      abandon the current vector and return to idle
//   in_valid   in_seq is valid
//   in_ready   block can take a vector (idle only)
//   in_seq     vector to scan
//   out_valid  beat valid
//   out_ready  downstream accepts the beat
//   out_onehot one-hot of the current priority bit (zero on an empty beat)
//   out_idx    binary index of that bit (zero on an empty beat)
//   out_last   final beat of this vector
//   out_zero   beat reports an all-zero input vector
module vector_scan_iter #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_seq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             zero_flag;

  logic [WIDTH-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             last_beat;

  // Priority select over the remaining bits. The loop walks from the
  // lowest-priority end so that the last hit is the winner.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (work[i]) begin
          pick     = '0;
          pick[i]  = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end else begin
        if (work[WIDTH-1-i]) begin
          pick              = '0;
          pick[WIDTH-1-i]   = 1'b1;
          pick_idx          = IDX_W'(WIDTH-1-i);
        end
      end
    end
  end

  // Last beat when nothing remains after the current pick, or when the
  // vector was empty to begin with (its single beat is also the last).
  assign last_beat = zero_flag | ((work & ~pick) == '0);

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == SCAN);
  // work and zero_flag are cleared whenever the block goes idle, so only
  // out_last needs explicit gating to stay low outside SCAN.
  assign out_onehot = pick;
  assign out_idx    = pick_idx;
  assign out_last   = out_valid & last_beat;
  assign out_zero   = zero_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      zero_flag <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      work      <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= in_seq;
            zero_flag <= (in_seq == '0);
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (last_beat) begin
              state     <= IDLE;
              work      <= '0;
              zero_flag <= 1'b0;
            end else begin
              work <= work & ~pick;
            end
          end
        end
        default: begin
          state     <= IDLE;
          work      <= '0;
          zero_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
